data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 240 ++++++++++++++++++++++++
 tb/tb_data_mem_resp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Byte-addressable data memory with a one-cycle registered
//               response, size/alignment/range checking and an optional
//               post-reset zeroing pass (scrub).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DEPTH_W     = 10,
    parameter int SCRUB_EN    = 1,
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,  // datapath is built for four byte lanes
    parameter int MEM_COUNT_W = 3,
    parameter int MEM_CODE_W  = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [ADDR_W-1:0]      i_mem_req_addr,
    input  logic [WORD_W-1:0]      i_mem_req_wr_data,
    input  logic                   i_mem_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
    output logic [WORD_W-1:0]      o_mem_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_mem_res_code,
    output logic                   o_ready
);

    localparam int c_LANES = 4;
    localparam int c_WORDS = 1 << DEPTH_W;

    localparam logic [0:0] c_ST_SCRUB = 1'b0;
    localparam logic [0:0] c_ST_SERVE = 1'b1;
    localparam logic [0:0] c_ST_RESET = (SCRUB_EN == 1) ? c_ST_SCRUB : c_ST_SERVE;

    localparam logic [MEM_CODE_W-1:0] c_CODE_IDLE  = MEM_CODE_W'(0);
    localparam logic [MEM_CODE_W-1:0] c_CODE_OK    = MEM_CODE_W'(1);
    localparam logic [MEM_CODE_W-1:0] c_CODE_FAULT = MEM_CODE_W'(2);
    localparam logic [MEM_CODE_W-1:0] c_CODE_BUSY  = MEM_CODE_W'(3);

    localparam logic [MEM_COUNT_W-1:0] c_CNT_1 = MEM_COUNT_W'(1);
    localparam logic [MEM_COUNT_W-1:0] c_CNT_2 = MEM_COUNT_W'(2);
    localparam logic [MEM_COUNT_W-1:0] c_CNT_4 = MEM_COUNT_W'(4);

    localparam logic [DEPTH_W-1:0] c_LAST_IDX = {DEPTH_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [DEPTH_W-1:0]    r_scrub_idx;
    logic [WORD_W-1:0]     r_rd_data;
    logic [MEM_CODE_W-1:0] r_code;
    logic                  r_ready;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic               w_present;
    logic [DEPTH_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic [4:0]         w_shift;
    logic               w_size_ok;
    logic               w_in_range;
    logic               w_legal;
    logic               w_serving;
    logic               w_scrubbing;
    logic               w_store;
    logic [c_LANES-1:0] w_req_be;

    assign w_present = |i_mem_req_count;
    assign w_idx     = i_mem_req_addr[DEPTH_W+1:2];
    assign w_lane    = i_mem_req_addr[1:0];
    assign w_shift   = {w_lane, 3'b000};

    always_comb begin
        w_size_ok = 1'b0;
        w_req_be  = '0;
        case (i_mem_req_count)
            c_CNT_1: begin
                w_size_ok = 1'b1;
                w_req_be  = 4'b0001 << w_lane;
            end
            c_CNT_2: begin
                w_size_ok = ~w_lane[0];
                w_req_be  = 4'b0011 << w_lane;
            end
            c_CNT_4: begin
                w_size_ok = (w_lane == 2'b00);
                w_req_be  = 4'b1111;
            end
            default: begin
                w_size_ok = 1'b0;
                w_req_be  = '0;
            end
        endcase
    end

    // Word index above the implemented depth must fault rather than alias.
    generate
        if (ADDR_W > DEPTH_W + 2) begin : g_range_chk
            assign w_in_range = ~|i_mem_req_addr[ADDR_W-1:DEPTH_W+2];
        end else begin : g_range_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_legal     = w_size_ok & w_in_range;
    assign w_serving   = (r_state == c_ST_SERVE);
    // Writes are suppressed while reset is held so contents survive reset.
    assign w_scrubbing = (r_state == c_ST_SCRUB) & aresetn;
    assign w_store     = w_serving & w_present & w_legal & i_mem_req_wr_en & aresetn;

    // ------------------------------------------------------------------------
    // Memory write port mux (scrub has priority; the two never overlap)
    // ------------------------------------------------------------------------
    logic [c_LANES-1:0] w_mem_we;
    logic [DEPTH_W-1:0] w_mem_idx;
    logic [WORD_W-1:0]  w_mem_wdata;
    logic [WORD_W-1:0]  w_rd_word;

    always_comb begin
        w_mem_we    = '0;
        w_mem_idx   = w_idx;
        w_mem_wdata = i_mem_req_wr_data << w_shift;
        if (w_scrubbing) begin
            w_mem_we    = {c_LANES{1'b1}};
            w_mem_idx   = r_scrub_idx;
            w_mem_wdata = '0;
        end else if (w_store) begin
            w_mem_we = w_req_be;
        end
    end

    // One bank per byte lane so each lane's write enable is independent.
    generate
        for (genvar l = 0; l < c_LANES; l++) begin : g_lane
            logic [7:0] r_bank [c_WORDS];

            always_ff @(posedge clk) begin
                if (w_mem_we[l]) begin
                    r_bank[w_mem_idx] <= w_mem_wdata[8*l +: 8];
                end
            end

            assign w_rd_word[8*l +: 8] = r_bank[w_idx];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Load data alignment
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0] w_rd_shifted;
    logic [WORD_W-1:0] w_load_data;

    assign w_rd_shifted = w_rd_word >> w_shift;

    always_comb begin
        w_load_data = w_rd_shifted;
        case (i_mem_req_count)
            c_CNT_1: w_load_data = {{(WORD_W-8){1'b0}}, w_rd_shifted[7:0]};
            c_CNT_2: w_load_data = {{(WORD_W-16){1'b0}}, w_rd_shifted[15:0]};
            default: w_load_data = w_rd_shifted;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= c_ST_RESET;
            r_scrub_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_SCRUB) begin
                r_scrub_idx <= r_scrub_idx + DEPTH_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_SCRUB: begin
                if (r_scrub_idx == c_LAST_IDX) begin
                    w_state_nxt = c_ST_SERVE;
                end
            end
            c_ST_SERVE: w_state_nxt = c_ST_SERVE;
            default:    w_state_nxt = c_ST_RESET;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: response outputs (next values, registered below)
    // ------------------------------------------------------------------------
    logic [MEM_CODE_W-1:0] w_code_nxt;
    logic [WORD_W-1:0]     w_rd_nxt;
    logic                  w_ready_nxt;

    always_comb begin
        w_code_nxt  = c_CODE_IDLE;
        w_rd_nxt    = '0;
        w_ready_nxt = (w_state_nxt == c_ST_SERVE);
        if (w_present) begin
            if (!w_serving) begin
                w_code_nxt = c_CODE_BUSY;
            end else if (!w_legal) begin
                w_code_nxt = c_CODE_FAULT;
            end else begin
                w_code_nxt = c_CODE_OK;
                if (!i_mem_req_wr_en) begin
                    w_rd_nxt = w_load_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_code    <= c_CODE_IDLE;
            r_rd_data <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_code    <= w_code_nxt;
            r_rd_data <= w_rd_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign o_mem_res_code    = r_code;
    assign o_mem_res_rd_data = r_rd_data;
    assign o_ready           = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Directed self-checking bench for data_mem_resp with a
//               byte-array reference model feeding a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam int DEPTH_W = 4;
    localparam int WORDS   = 1 << DEPTH_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_OK    = 2'd1;
    localparam logic [1:0] c_FAULT = 2'd2;
    localparam logic [1:0] c_BUSY  = 2'd3;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  cnt;
    logic [31:0] rd;
    logic [1:0]  code;
    logic        ready;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] data;
        logic        ready;
        string       tag;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_bytes [4*WORDS];
    int         m_scrub_left = 0;
    int         total = 0;
    int         bad   = 0;

    data_mem_resp #(
        .DEPTH_W (DEPTH_W),
        .SCRUB_EN(1)
    ) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .i_mem_req_addr   (addr),
        .i_mem_req_wr_data(wd),
        .i_mem_req_wr_en  (we),
        .i_mem_req_count  (cnt),
        .o_mem_res_rd_data(rd),
        .o_mem_res_code   (code),
        .o_ready          (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({e.tag, ".code"},  32'(code),  32'(e.code));
        check({e.tag, ".data"},  rd,         e.data);
        check({e.tag, ".ready"}, 32'(ready), 32'(e.ready));
    endtask

    // Byte-array reference: little-endian, one entry per byte address.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [2:0] c, output exp_t e);
        bit ok;
        int base;
        e.code  = c_IDLE;
        e.data  = '0;
        e.ready = 1'b1;
        e.tag   = "";
        if (m_scrub_left > 0) begin
            m_scrub_left--;
            e.ready = (m_scrub_left == 0);
            if (c != 3'd0) e.code = c_BUSY;
            return;
        end
        if (c == 3'd0) return;
        ok = (c == 3'd1) || (c == 3'd2 && a[0] == 1'b0) || (c == 3'd4 && a[1:0] == 2'b00);
        if (a[31:2] >= 30'(WORDS)) ok = 1'b0;
        if (!ok) begin
            e.code = c_FAULT;
            return;
        end
        e.code = c_OK;
        base   = int'(a[5:0]);
        for (int i = 0; i < int'(c); i++) begin
            if (w) m_bytes[base+i] = d[8*i +: 8];
            else   e.data[8*i +: 8] = m_bytes[base+i];
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [2:0] c, input string tag, input bit use_k,
                         input logic [1:0] kc, input logic [31:0] kd);
        exp_t e;
        addr = a;
        wd   = d;
        we   = w;
        cnt  = c;
        model(a, d, w, c, e);
        if (use_k) begin
            e.code = kc;
            e.data = kd;
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [2:0] c, input string tag);
        @(negedge clk);
        check_one();
        apply(a, d, w, c, tag, 1'b0, c_IDLE, 32'h0);
    endtask

    task automatic drive_k(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic [2:0] c, input logic [1:0] kc,
                           input logic [31:0] kd, input string tag);
        @(negedge clk);
        check_one();
        apply(a, d, w, c, tag, 1'b1, kc, kd);
    endtask

    task automatic rst_check(input string tag);
        check({tag, ".code"},  32'(code),  32'(c_IDLE));
        check({tag, ".data"},  rd,         32'h0);
        check({tag, ".ready"}, 32'(ready), 32'h0);
        check({tag, ".idx"},   32'(dut.r_scrub_idx), 32'h0);
    endtask

    task automatic enter_reset(input int idx_before, input string tag);
        @(negedge clk);
        check_one();
        check({tag, ".idx_before"}, 32'(dut.r_scrub_idx), 32'(idx_before));
        aresetn = 1'b0;
        addr = 32'h0;
        we   = 1'b0;
        cnt  = 3'd4;
        #1;
        rst_check({tag, ".async"});
        @(negedge clk);
        rst_check({tag, ".hold"});
    endtask

    // Releases reset and presents the first request before the next edge.
    task automatic release_rst(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic [2:0] c, input string tag);
        @(negedge clk);
        aresetn      = 1'b1;
        m_scrub_left = WORDS;
        for (int i = 0; i < 4*WORDS; i++) m_bytes[i] = 8'h00;
        apply(a, d, w, c, tag, 1'b0, c_IDLE, 32'h0);
    endtask

    initial begin
        aresetn = 1'b1;
        addr    = 32'h0;
        wd      = 32'h0;
        we      = 1'b0;
        cnt     = 3'd0;
        #2;
        aresetn = 1'b0;
        cnt     = 3'd4;
        @(negedge clk);
        rst_check("por");
        @(negedge clk);
        rst_check("por_hold");

        // Scrub: held word load answered BUSY for WORDS cycles, then served.
        release_rst(32'h0, 32'h0, 1'b0, 3'd4, "scrub");
        for (int i = 1; i < WORDS; i++) drive(32'h0, 32'h0, 1'b0, 3'd4, "scrub");
        drive_k(32'h00, 32'h0, 1'b0, 3'd4, c_OK, 32'h0, "post_scrub_ld0");
        drive(32'h3C, 32'h0, 1'b0, 3'd4, "post_scrub_ld_last");

        // Byte lanes
        drive_k(32'h10, 32'h11223344, 1'b1, 3'd4, c_OK, 32'h0, "st_word");
        drive_k(32'h12, 32'hFFFFFFAA, 1'b1, 3'd1, c_OK, 32'h0, "st_byte");
        drive_k(32'h10, 32'h0, 1'b0, 3'd4, c_OK, 32'h11AA3344, "ld_word");
        drive_k(32'h12, 32'h0, 1'b0, 3'd2, c_OK, 32'h000011AA, "ld_half");
        drive(32'h13, 32'h0, 1'b0, 3'd1, "ld_byte3");
        drive(32'h16, 32'h1234CAFE, 1'b1, 3'd2, "st_half_hi");
        drive(32'h14, 32'h0, 1'b0, 3'd4, "ld_word5");

        // Faults: alignment, size and range; none may write
        drive_k(32'h02, 32'h0, 1'b0, 3'd4, c_FAULT, 32'h0, "flt_w_align");
        drive_k(32'h01, 32'h0, 1'b0, 3'd2, c_FAULT, 32'h0, "flt_h_align");
        drive_k(32'h00, 32'h0, 1'b0, 3'd3, c_FAULT, 32'h0, "flt_cnt3");
        drive_k(32'h40, 32'h0, 1'b0, 3'd4, c_FAULT, 32'h0, "flt_range");
        drive(32'h00, 32'h0, 1'b0, 3'd7, "flt_cnt7");
        drive(32'h12, 32'hFFFFFFFF, 1'b1, 3'd4, "flt_st_align");
        drive(32'h11, 32'hFFFFFFFF, 1'b1, 3'd2, "flt_st_half");
        drive(32'h44, 32'hFFFFFFFF, 1'b1, 3'd1, "flt_st_range");
        drive(32'h10, 32'h0, 1'b0, 3'd4, "flt_unchanged");
        drive(32'h04, 32'h0, 1'b0, 3'd4, "flt_no_alias");

        // Idle request with wr_en high must not touch memory
        drive_k(32'h10, 32'h55555555, 1'b1, 3'd0, c_IDLE, 32'h0, "idle_we");
        drive(32'h10, 32'h0, 1'b0, 3'd4, "idle_unchanged");

        // Back-to-back store then load
        drive(32'h20, 32'hDEADBEEF, 1'b1, 3'd4, "b2b_st");
        drive_k(32'h20, 32'h0, 1'b0, 3'd4, c_OK, 32'hDEADBEEF, "b2b_ld");
        drive(32'h21, 32'h00000055, 1'b1, 3'd1, "b2b_st_byte");
        drive(32'h21, 32'h0, 1'b0, 3'd1, "b2b_ld_byte");
        drive(32'h20, 32'h0, 1'b0, 3'd4, "b2b_ld_word");

        // Reset mid-scrub at index 5, then the scrub restarts from 0
        enter_reset(0, "rst_serve");
        release_rst(32'h0, 32'h0, 1'b0, 3'd4, "scrub2");
        for (int i = 1; i < 5; i++) drive(32'h0, 32'h0, 1'b0, 3'd4, "scrub2");
        enter_reset(5, "rst_mid");
        release_rst(32'h0, 32'hFFFFFFFF, 1'b1, 3'd4, "scrub3");
        for (int i = 1; i < WORDS; i++) drive(32'h0, 32'hFFFFFFFF, 1'b1, 3'd4, "scrub3");
        drive_k(32'h00, 32'h0, 1'b0, 3'd4, c_OK, 32'h0, "rescrub_ld0");
        drive(32'h20, 32'h0, 1'b0, 3'd4, "rescrub_ld20");
        drive(32'h10, 32'h0, 1'b0, 3'd4, "rescrub_ld10");
        drive(32'h3C, 32'h0, 1'b0, 3'd4, "rescrub_ld3c");

        @(negedge clk);
        check_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
